// File: rtl/control_sequencer.sv
// control_sequencer -- hardwired control unit for the Datapath.
//
// Fetches an instruction (T0..T2), decodes IR[31:27] and sequences the
// register-transfer steps T3..T6 for R-format ALU, mul/div, neg/not, nop
// and halt. All outputs are decoded combinationally from the present state
// and IR, so an asynchronous clr clears them without waiting for a clock.
//
// Optional build macro: CS_SINGLE_STEP_EN
//   Adds input 'step' and a WAIT state. Completed instructions park in WAIT
//   (run=1, all strobes 0) until a posedge with step=1 releases the next one.
//
// Ports:
//   clk, clr                 clock, asynchronous active-high reset
//   step                     single-step release (CS_SINGLE_STEP_EN only)
//   IR[31:0]                 instruction register from the Datapath
//   R_rd, R_wrt [NREG-1:0]   one-hot register load / bus-drive
//   PC_out, MDR_out,
//   Zlo_out, Zhi_out         bus source selects (at most one active)
//   MAR_rd, PC_rd, MDR_rd,
//   IR_rd, Y_rd, Zlo_rd,
//   HI_rd, LO_rd             register load strobes (Zlo_rd loads all of Z)
//   IncPC, Read              PC increment, memory read into MDR
//   op_sel[OPW-1:0]          ALU operation select (non-zero only in T4)
//   run                      high while executing (low in RST and HALT)

module control_sequencer #(
  parameter int NREG = 16,
  parameter int OPW  = 5
) (
  input  logic            clk,
  input  logic            clr,
`ifdef CS_SINGLE_STEP_EN
  input  logic            step,
`endif
  input  logic [31:0]     IR,
  output logic [NREG-1:0] R_rd,
  output logic [NREG-1:0] R_wrt,
  output logic            PC_out,
  output logic            MDR_out,
  output logic            Zlo_out,
  output logic            Zhi_out,
  output logic            MAR_rd,
  output logic            PC_rd,
  output logic            MDR_rd,
  output logic            IR_rd,
  output logic            Y_rd,
  output logic            Zlo_rd,
  output logic            HI_rd,
  output logic            LO_rd,
  output logic            IncPC,
  output logic            Read,
  output logic [OPW-1:0]  op_sel,
  output logic            run
);

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
`ifdef CS_SINGLE_STEP_EN
    , S_WAIT
`endif
  } state_t;

  // Where a completed instruction goes next.
`ifdef CS_SINGLE_STEP_EN
  localparam state_t S_DONE = S_WAIT;
`else
  localparam state_t S_DONE = S_T0;
`endif

  localparam logic [OPW-1:0] OP_ADD  = OPW'(3);
  localparam logic [OPW-1:0] OP_ROL  = OPW'(11);
  localparam logic [OPW-1:0] OP_MUL  = OPW'(15);
  localparam logic [OPW-1:0] OP_DIV  = OPW'(16);
  localparam logic [OPW-1:0] OP_NEG  = OPW'(17);
  localparam logic [OPW-1:0] OP_NOT  = OPW'(18);
  localparam logic [OPW-1:0] OP_HALT = OPW'(27);

  state_t          state_q;
  logic [OPW-1:0]  opcode;
  logic [3:0]      ra, rb, rc;
  logic [NREG-1:0] ra_hot, rb_hot, rc_hot;
  logic            is_alu, is_muldiv, is_unary, is_halt;
  logic            unused_ir;

  assign opcode = IR[31 -: OPW];
  assign ra     = IR[26:23];
  assign rb     = IR[22:19];
  assign rc     = IR[18:15];
  assign unused_ir = ^IR[14:0];

  assign is_alu    = (opcode >= OP_ADD) && (opcode <= OP_ROL);
  assign is_muldiv = (opcode == OP_MUL) || (opcode == OP_DIV);
  assign is_unary  = (opcode == OP_NEG) || (opcode == OP_NOT);
  assign is_halt   = (opcode == OP_HALT);

  // One-hot decode of the register fields; indices >= NREG match no bit
  // and therefore produce an all-zero vector.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_hot
    localparam logic [31:0] IDX = gi;
    assign ra_hot[gi] = ({28'd0, ra} == IDX);
    assign rb_hot[gi] = ({28'd0, rb} == IDX);
    assign rc_hot[gi] = ({28'd0, rc} == IDX);
  end

  // State register. The decode in T2 looks at IR while IR_rd is asserted,
  // so the Datapath must present the fetched word on IR during T2.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_RST;
    end else begin
      case (state_q)
        S_RST:  state_q <= S_T0;
        S_T0:   state_q <= S_T1;
        S_T1:   state_q <= S_T2;
        S_T2: begin
          if (is_alu || is_muldiv) state_q <= S_T3;
          else if (is_unary)       state_q <= S_T4;
          else if (is_halt)        state_q <= S_HALT;
          else                     state_q <= S_DONE;
        end
        S_T3:   state_q <= S_T4;
        S_T4:   state_q <= S_T5;
        S_T5:   state_q <= is_muldiv ? S_T6 : S_DONE;
        S_T6:   state_q <= S_DONE;
        S_HALT: state_q <= S_HALT;
`ifdef CS_SINGLE_STEP_EN
        S_WAIT: state_q <= step ? S_T0 : S_WAIT;
`endif
        default: state_q <= S_RST;
      endcase
    end
  end

  always_comb begin
    R_rd    = '0;
    R_wrt   = '0;
    PC_out  = 1'b0;
    MDR_out = 1'b0;
    Zlo_out = 1'b0;
    Zhi_out = 1'b0;
    MAR_rd  = 1'b0;
    PC_rd   = 1'b0;
    MDR_rd  = 1'b0;
    IR_rd   = 1'b0;
    Y_rd    = 1'b0;
    Zlo_rd  = 1'b0;
    HI_rd   = 1'b0;
    LO_rd   = 1'b0;
    IncPC   = 1'b0;
    Read    = 1'b0;
    op_sel  = '0;
    run     = 1'b1;
    case (state_q)
      S_T0: begin
        PC_out = 1'b1;
        MAR_rd = 1'b1;
        IncPC  = 1'b1;
      end
      S_T1: begin
        Read   = 1'b1;
        MDR_rd = 1'b1;
      end
      S_T2: begin
        MDR_out = 1'b1;
        IR_rd   = 1'b1;
      end
      S_T3: begin
        // mul/div name their operands Ra,Rb (result goes to HI/LO), so the
        // first operand comes from Ra; ALU ops take it from Rb.
        R_wrt = is_muldiv ? ra_hot : rb_hot;
        Y_rd  = 1'b1;
      end
      S_T4: begin
        // Second operand: Rc for three-register ALU ops, Rb for mul/div and
        // for the single operand of neg/not.
        R_wrt  = is_alu ? rc_hot : rb_hot;
        op_sel = opcode;
        Zlo_rd = 1'b1;
      end
      S_T5: begin
        Zlo_out = 1'b1;
        if (is_muldiv) LO_rd = 1'b1;
        else           R_rd  = ra_hot;
      end
      S_T6: begin
        Zhi_out = 1'b1;
        HI_rd   = 1'b1;
      end
`ifdef CS_SINGLE_STEP_EN
      S_WAIT: run = 1'b1;
`endif
      default: run = 1'b0;   // RST and HALT
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  localparam int NREG = 16;
  localparam int OPW  = 5;

  // Strobe vector bit order:
  // {PC_out, MDR_out, Zlo_out, Zhi_out, MAR_rd, PC_rd, MDR_rd, IR_rd,
  //  Y_rd, Zlo_rd, HI_rd, LO_rd, IncPC, Read}
  localparam logic [13:0] S_PC_OUT  = 14'h2000;
  localparam logic [13:0] S_MDR_OUT = 14'h1000;
  localparam logic [13:0] S_ZLO_OUT = 14'h0800;
  localparam logic [13:0] S_ZHI_OUT = 14'h0400;
  localparam logic [13:0] S_MAR_RD  = 14'h0200;
  localparam logic [13:0] S_MDR_RD  = 14'h0080;
  localparam logic [13:0] S_IR_RD   = 14'h0040;
  localparam logic [13:0] S_Y_RD    = 14'h0020;
  localparam logic [13:0] S_ZLO_RD  = 14'h0010;
  localparam logic [13:0] S_HI_RD   = 14'h0008;
  localparam logic [13:0] S_LO_RD   = 14'h0004;
  localparam logic [13:0] S_INCPC   = 14'h0002;
  localparam logic [13:0] S_READ    = 14'h0001;

  localparam logic [13:0] ST_T0 = S_PC_OUT | S_MAR_RD | S_INCPC;
  localparam logic [13:0] ST_T1 = S_READ | S_MDR_RD;
  localparam logic [13:0] ST_T2 = S_MDR_OUT | S_IR_RD;

  localparam logic [31:0] IR_ROR  = 32'h52438000;  // ror R4,R8,R7
  localparam logic [31:0] IR_MUL  = 32'h7A280000;  // mul R4,R5
  localparam logic [31:0] IR_NOT  = 32'h92280000;  // not R4,R5
  localparam logic [31:0] IR_UNK  = 32'hFA280000;  // opcode 11111
  localparam logic [31:0] IR_ADD0 = 32'h18090000;  // add R0,R1,R2
  localparam logic [31:0] IR_NOP  = 32'hD0000000;
  localparam logic [31:0] IR_HALT = 32'hD8000000;

  typedef struct {
    string       name;
    logic [31:0] ir;
    logic [15:0] rd;
    logic [15:0] wrt;
    logic [4:0]  op;
    logic [13:0] st;
    logic        run;
    logic        last;   // instruction completes after this state
  } vec_t;

  logic clk;
  logic clr;
  logic [31:0] IR;
`ifdef CS_SINGLE_STEP_EN
  logic step;
`endif
  logic [NREG-1:0] R_rd, R_wrt;
  logic PC_out, MDR_out, Zlo_out, Zhi_out;
  logic MAR_rd, PC_rd, MDR_rd, IR_rd, Y_rd, Zlo_rd, HI_rd, LO_rd;
  logic IncPC, Read, run;
  logic [OPW-1:0] op_sel;

  int chk_cnt;
  int pass_cnt;
  vec_t vecs[$];

  control_sequencer #(.NREG(NREG), .OPW(OPW)) dut (
    .clk     (clk),
    .clr     (clr),
`ifdef CS_SINGLE_STEP_EN
    .step    (step),
`endif
    .IR      (IR),
    .R_rd    (R_rd),
    .R_wrt   (R_wrt),
    .PC_out  (PC_out),
    .MDR_out (MDR_out),
    .Zlo_out (Zlo_out),
    .Zhi_out (Zhi_out),
    .MAR_rd  (MAR_rd),
    .PC_rd   (PC_rd),
    .MDR_rd  (MDR_rd),
    .IR_rd   (IR_rd),
    .Y_rd    (Y_rd),
    .Zlo_rd  (Zlo_rd),
    .HI_rd   (HI_rd),
    .LO_rd   (LO_rd),
    .IncPC   (IncPC),
    .Read    (Read),
    .op_sel  (op_sel),
    .run     (run)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [15:0] e_rd,
                       input logic [15:0] e_wrt, input logic [4:0] e_op,
                       input logic [13:0] e_st, input logic e_run);
    logic [13:0] a_st;
    int nbus;
    a_st = {PC_out, MDR_out, Zlo_out, Zhi_out, MAR_rd, PC_rd, MDR_rd, IR_rd,
            Y_rd, Zlo_rd, HI_rd, LO_rd, IncPC, Read};
    chk_cnt++;
    if (R_rd === e_rd && R_wrt === e_wrt && op_sel === e_op &&
        a_st === e_st && run === e_run) begin
      pass_cnt++;
      $display("%-16s ok   rd=%h wrt=%h op=%b st=%b run=%b",
               name, R_rd, R_wrt, op_sel, a_st, run);
    end else begin
      $display("FAIL %s: got rd=%h wrt=%h op=%b st=%b run=%b, expected rd=%h wrt=%h op=%b st=%b run=%b",
               name, R_rd, R_wrt, op_sel, a_st, run, e_rd, e_wrt, e_op, e_st, e_run);
    end
    // at most one bus source may be active
    nbus = $countones(R_wrt) + int'(PC_out) + int'(MDR_out) + int'(Zlo_out) + int'(Zhi_out);
    chk_cnt++;
    if (nbus <= 1) pass_cnt++;
    else $display("FAIL %s bus: got %0d drivers, expected at most 1", name, nbus);
  endtask

  task automatic addv(input string name, input logic [31:0] ir,
                      input logic [15:0] rd, input logic [15:0] wrt,
                      input logic [4:0] op, input logic [13:0] st,
                      input logic last);
    vec_t v;
    v.name = name; v.ir = ir; v.rd = rd; v.wrt = wrt; v.op = op;
    v.st = st; v.run = (name != "halt"); v.last = last;
    vecs.push_back(v);
  endtask

  task automatic fetch3(input string tag, input logic [31:0] ir, input logic last2);
    addv({tag, " T0"}, ir, 16'h0, 16'h0, 5'b0, ST_T0, 1'b0);
    addv({tag, " T1"}, ir, 16'h0, 16'h0, 5'b0, ST_T1, 1'b0);
    addv({tag, " T2"}, ir, 16'h0, 16'h0, 5'b0, ST_T2, last2);
  endtask

  initial begin
    chk_cnt  = 0;
    pass_cnt = 0;
    clr = 1'b1;
    IR  = 32'h0;
`ifdef CS_SINGLE_STEP_EN
    step = 1'b0;
`endif

    // ror R4,R8,R7: 6 cycles
    fetch3("ror", IR_ROR, 1'b0);
    addv("ror T3", IR_ROR, 16'h0000, 16'h0100, 5'b00000, S_Y_RD, 1'b0);
    addv("ror T4", IR_ROR, 16'h0000, 16'h0080, 5'b01010, S_ZLO_RD, 1'b0);
    addv("ror T5", IR_ROR, 16'h0010, 16'h0000, 5'b00000, S_ZLO_OUT, 1'b1);
    // mul R4,R5: 7 cycles, R_rd never set
    fetch3("mul", IR_MUL, 1'b0);
    addv("mul T3", IR_MUL, 16'h0000, 16'h0010, 5'b00000, S_Y_RD, 1'b0);
    addv("mul T4", IR_MUL, 16'h0000, 16'h0020, 5'b01111, S_ZLO_RD, 1'b0);
    addv("mul T5", IR_MUL, 16'h0000, 16'h0000, 5'b00000, S_ZLO_OUT | S_LO_RD, 1'b0);
    addv("mul T6", IR_MUL, 16'h0000, 16'h0000, 5'b00000, S_ZHI_OUT | S_HI_RD, 1'b1);
    // not R4,R5: T3 skipped, 5 cycles
    fetch3("not", IR_NOT, 1'b0);
    addv("not T4", IR_NOT, 16'h0000, 16'h0020, 5'b10010, S_ZLO_RD, 1'b0);
    addv("not T5", IR_NOT, 16'h0010, 16'h0000, 5'b00000, S_ZLO_OUT, 1'b1);
    // unknown opcode: 3 cycles, no register activity
    fetch3("unk", IR_UNK, 1'b1);
    // add R0,R1,R2: destination R0 is written like any other
    fetch3("add0", IR_ADD0, 1'b0);
    addv("add0 T3", IR_ADD0, 16'h0000, 16'h0002, 5'b00000, S_Y_RD, 1'b0);
    addv("add0 T4", IR_ADD0, 16'h0000, 16'h0004, 5'b00011, S_ZLO_RD, 1'b0);
    addv("add0 T5", IR_ADD0, 16'h0001, 16'h0000, 5'b00000, S_ZLO_OUT, 1'b1);
    // nop: 3 cycles
    fetch3("nop", IR_NOP, 1'b1);
    // halt
    fetch3("hlt", IR_HALT, 1'b0);
    addv("halt", IR_HALT, 16'h0000, 16'h0000, 5'b00000, 14'h0, 1'b0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset", 16'h0, 16'h0, 5'b0, 14'h0, 1'b0);
    clr = 1'b0;

    // table-driven: one vector per clock, state entered on each posedge
    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
`ifdef CS_SINGLE_STEP_EN
      step = 1'b0;
`endif
      IR = vecs[i].ir;
      @(negedge clk);
      check(vecs[i].name, vecs[i].rd, vecs[i].wrt, vecs[i].op, vecs[i].st, vecs[i].run);
`ifdef CS_SINGLE_STEP_EN
      if (vecs[i].last) begin
        @(posedge clk);
        @(negedge clk);
        check("wait", 16'h0, 16'h0, 5'b0, 14'h0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        check("wait hold", 16'h0, 16'h0, 5'b0, 14'h0, 1'b1);
        step = 1'b1;   // next posedge releases one instruction
      end
`endif
    end

    // halt holds for 20 clocks
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("halt hold %0d", k), 16'h0, 16'h0, 5'b0, 14'h0, 1'b0);
    end

    // clr out of HALT, then release: RST, then T0
    clr = 1'b1;
    #1;
    check("clr from halt", 16'h0, 16'h0, 5'b0, 14'h0, 1'b0);
    @(negedge clk);
    clr = 1'b0;
    #1;
    check("rst released", 16'h0, 16'h0, 5'b0, 14'h0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("T0 after rst", 16'h0, 16'h0, 5'b0, ST_T0, 1'b1);

    // add R0,R1,R2 aborted mid-T4 by clr (no clock edge involved)
    IR = IR_ADD0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("abort add T4", 16'h0, 16'h0004, 5'b00011, S_ZLO_RD, 1'b1);
    #2;
    clr = 1'b1;
    #1;
    check("clr mid T4", 16'h0, 16'h0, 5'b0, 14'h0, 1'b0);
    @(negedge clk);
    clr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("T0 after abort", 16'h0, 16'h0, 5'b0, ST_T0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    check("T1 after abort", 16'h0, 16'h0, 5'b0, ST_T1, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
